// File: rtl/ro_slave_responder_pkg.sv
// ro_slave_responder_pkg: shared read-port widths, default out-of-range data and responder states
package ro_slave_responder_pkg;
   localparam int RO_DATA_WIDTH = 32;
   localparam int RO_SLAVE_ADDR_WIDTH = 10;
   localparam logic [RO_DATA_WIDTH-1:0] RO_OOR_DATA = 32'h0000_0000;
   typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;
endpackage

// File: rtl/ro_slave_responder.sv
// ro_slave_responder: slave end of the read-only data port, one SRAM read per granted request
module ro_slave_responder
   import ro_slave_responder_pkg::*;
#(
   parameter int DATA_WIDTH = RO_DATA_WIDTH,
   parameter int SLAVE_ADDR_WIDTH = RO_SLAVE_ADDR_WIDTH,
   parameter int MEM_ADDR_WIDTH = 8,
   parameter int WAIT_STATES = 0,
   parameter logic [DATA_WIDTH-1:0] OOR_DATA = DATA_WIDTH'(RO_OOR_DATA)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        slave_data_req_i,
   input  logic [SLAVE_ADDR_WIDTH-1:0] slave_data_addr_i,
   output logic                        slave_data_gnt_o,
   output logic                        slave_data_rvalid_o,
   output logic [DATA_WIDTH-1:0]       slave_data_rdata_o,
   output logic                        mem_csb_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   input  logic [DATA_WIDTH-1:0]       mem_rdata_i
);
   state_t state;
   logic [3:0] cnt;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic oor;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] resp_data;
   logic capture;
   assign capture = (state == IDLE || state == RESP) && slave_data_req_i;
   assign resp_data = oor ? OOR_DATA : mem_rdata_i;
   assign slave_data_gnt_o = state == ISSUE;
   assign slave_data_rvalid_o = state == RESP;
   assign slave_data_rdata_o = slave_data_rvalid_o ? resp_data : rdata_q;
   assign mem_csb_o = !(state == ISSUE && !oor);
   assign mem_addr_o = addr_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         addr_q <= '0;
         oor <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (state == RESP) rdata_q <= resp_data;
         if (capture) begin
            addr_q <= slave_data_addr_i[MEM_ADDR_WIDTH-1:0];
            oor <= (slave_data_addr_i >> MEM_ADDR_WIDTH) != '0;
            cnt <= 4'(WAIT_STATES);
            state <= WAIT_STATES > 0 ? WAIT : ISSUE;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
            state <= !slave_data_req_i ? IDLE : cnt == 4'd1 ? ISSUE : WAIT;
         end else if (state == ISSUE) begin
            state <= slave_data_req_i ? RESP : IDLE;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_ro_slave_responder.sv
// tb_ro_slave_responder: vector table plus scoreboard checks across three wait-state configurations
module tb_ro_slave_responder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] sb_exp;
   typedef struct {
      logic [9:0]  addr;
      logic        oor;
      logic [31:0] rdata;
   } vec_t;
   vec_t vecs[7];
   logic req0, req2, req3;
   logic [9:0] addr0, addr2, addr3;
   logic gnt0, gnt2, gnt3, rv0, rv2, rv3, csb0, csb2, csb3;
   logic [31:0] rd0, rd2, rd3, mq0, mq2, mq3;
   logic [7:0] ma0, ma2, ma3;
   ro_slave_responder #(.WAIT_STATES(0), .OOR_DATA(32'hDEAD_BEEF)) u0 (
      .clk(clk), .reset(reset), .slave_data_req_i(req0), .slave_data_addr_i(addr0),
      .slave_data_gnt_o(gnt0), .slave_data_rvalid_o(rv0), .slave_data_rdata_o(rd0),
      .mem_csb_o(csb0), .mem_addr_o(ma0), .mem_rdata_i(mq0));
   ro_slave_responder #(.WAIT_STATES(2)) u2 (
      .clk(clk), .reset(reset), .slave_data_req_i(req2), .slave_data_addr_i(addr2),
      .slave_data_gnt_o(gnt2), .slave_data_rvalid_o(rv2), .slave_data_rdata_o(rd2),
      .mem_csb_o(csb2), .mem_addr_o(ma2), .mem_rdata_i(mq2));
   ro_slave_responder #(.WAIT_STATES(3)) u3 (
      .clk(clk), .reset(reset), .slave_data_req_i(req3), .slave_data_addr_i(addr3),
      .slave_data_gnt_o(gnt3), .slave_data_rvalid_o(rv3), .slave_data_rdata_o(rd3),
      .mem_csb_o(csb3), .mem_addr_o(ma3), .mem_rdata_i(mq3));
   always @(posedge clk) begin
      if (!csb0) mq0 <= {16'hCAFE, 8'h00, ma0};
      if (!csb2) mq2 <= {16'hCAFE, 8'h00, ma2};
      if (!csb3) mq3 <= {16'hCAFE, 8'h00, ma3};
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (!reset && rv0) begin
         if (exp_q.size() == 0) chk("sb_unexpected_rvalid", 32'(rv0), 32'd0);
         else begin
            sb_exp = exp_q.pop_front();
            chk("sb_rdata", rd0, sb_exp);
         end
      end
   end
   initial begin
      int low;
      req0 = 0; req2 = 0; req3 = 0;
      addr0 = '0; addr2 = '0; addr3 = '0;
      vecs[0] = '{10'h005, 1'b0, 32'hCAFE_0005};
      vecs[1] = '{10'h000, 1'b0, 32'hCAFE_0000};
      vecs[2] = '{10'h0FF, 1'b0, 32'hCAFE_00FF};
      vecs[3] = '{10'h100, 1'b1, 32'hDEAD_BEEF};
      vecs[4] = '{10'h3FF, 1'b1, 32'hDEAD_BEEF};
      vecs[5] = '{10'h080, 1'b0, 32'hCAFE_0080};
      vecs[6] = '{10'h1FF, 1'b1, 32'hDEAD_BEEF};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt0), 0);
      chk("rst_rvalid", 32'(rv0), 0);
      chk("rst_rdata", rd0, 0);
      chk("rst_csb", 32'(csb0), 1);
      chk("rst_mem_addr", 32'(ma0), 0);
      chk("rst_csb_ws3", 32'(csb3), 1);
      reset = 0;
      step();
      foreach (vecs[i]) begin
         req0 = 1; addr0 = vecs[i].addr;
         exp_q.push_back(vecs[i].rdata);
         step();
         chk("tbl_gnt", 32'(gnt0), 1);
         chk("tbl_csb", 32'(csb0), 32'(vecs[i].oor));
         chk("tbl_rvalid_early", 32'(rv0), 0);
         if (!vecs[i].oor) chk("tbl_mem_addr", 32'(ma0), 32'(vecs[i].addr[7:0]));
         step();
         chk("tbl_rvalid", 32'(rv0), 1);
         chk("tbl_gnt_pulse", 32'(gnt0), 0);
         chk("tbl_csb_resp", 32'(csb0), 1);
         req0 = 0;
         step();
         chk("tbl_rvalid_pulse", 32'(rv0), 0);
         chk("tbl_rdata_hold", rd0, vecs[i].rdata);
      end
      req0 = 1; addr0 = 10'h001;
      exp_q.push_back(32'hCAFE_0001);
      step();
      chk("b2b_gnt1", 32'(gnt0), 1);
      chk("b2b_addr1", 32'(ma0), 1);
      step();
      chk("b2b_rvalid1", 32'(rv0), 1);
      addr0 = 10'h002;
      exp_q.push_back(32'hCAFE_0002);
      step();
      chk("b2b_gnt2", 32'(gnt0), 1);
      chk("b2b_csb2", 32'(csb0), 0);
      chk("b2b_addr2", 32'(ma0), 2);
      step();
      chk("b2b_rvalid2", 32'(rv0), 1);
      req0 = 0;
      step();
      chk("b2b_idle", 32'(rv0), 0);
      req3 = 1; addr3 = 10'h020; low = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (!csb3) low++;
         chk($sformatf("ws3_gnt_c%0d", c), 32'(gnt3), 32'(c == 4));
         chk($sformatf("ws3_rvalid_c%0d", c), 32'(rv3), 32'(c == 5));
         if (c == 4) chk("ws3_mem_addr", 32'(ma3), 32'h20);
         if (c == 5) begin
            chk("ws3_rdata", rd3, 32'hCAFE_0020);
            req3 = 0;
         end
      end
      chk("ws3_csb_low_cycles", low, 1);
      req2 = 1; addr2 = 10'h010;
      for (int c = 1; c <= 6; c++) begin
         step();
         chk($sformatf("abort_gnt_c%0d", c), 32'(gnt2), 0);
         chk($sformatf("abort_rvalid_c%0d", c), 32'(rv2), 0);
         chk($sformatf("abort_csb_c%0d", c), 32'(csb2), 1);
         if (c == 2) req2 = 0;
         if (c == 4) begin
            req2 = 1; addr2 = 10'h011;
         end
      end
      step();
      chk("abort_fresh_gnt", 32'(gnt2), 1);
      chk("abort_fresh_csb", 32'(csb2), 0);
      chk("abort_fresh_addr", 32'(ma2), 32'h11);
      step();
      chk("abort_fresh_rvalid", 32'(rv2), 1);
      chk("abort_fresh_rdata", rd2, 32'hCAFE_0011);
      req2 = 0;
      step();
      chk("abort_fresh_pulse", 32'(rv2), 0);
      req0 = 1; addr0 = 10'h007;
      step();
      chk("rstmid_gnt_before", 32'(gnt0), 1);
      #2 reset = 1;
      #1;
      chk("rstmid_gnt", 32'(gnt0), 0);
      chk("rstmid_csb", 32'(csb0), 1);
      chk("rstmid_rvalid", 32'(rv0), 0);
      chk("rstmid_rdata", rd0, 0);
      chk("rstmid_mem_addr", 32'(ma0), 0);
      req0 = 0;
      step();
      reset = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rstmid_no_rvalid", 32'(rv0), 0);
         chk("rstmid_no_gnt", 32'(gnt0), 0);
      end
      chk("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ro_slave_responder.md
Name: ro_slave_responder

Overview:
- Slave-side end of the read-only data port protocol.
- Accepts slave_data_req/slave_data_addr from one slave port of the read interconnect.
- Issues one read per request to a single-port synchronous SRAM macro (1-cycle read latency, active-low chip select).
- Asserts gnt on acceptance and returns the captured read word with a one-cycle rvalid pulse.
- Configurable wait states model slow macros; the address range is checked.

Parameters:
- DATA_WIDTH, 32, read data width.
- SLAVE_ADDR_WIDTH, 10, word address width on the slave port.
- MEM_ADDR_WIDTH, 8, SRAM word address width; must be <= SLAVE_ADDR_WIDTH.
- WAIT_STATES, 0, extra cycles between request capture and SRAM issue (0..15).
- OOR_DATA, 32'h0000_0000, data returned for out-of-range addresses.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- slave_data_req_i  input  1  read request from the interconnect.
- slave_data_addr_i  input  SLAVE_ADDR_WIDTH  word address.
- slave_data_gnt_o  output  1  request accepted; one-cycle pulse.
- slave_data_rvalid_o  output  1  slave_data_rdata_o valid; one-cycle pulse.
- slave_data_rdata_o  output  DATA_WIDTH  read data; held until the next response.
- mem_csb_o  output  1  SRAM chip select, active low.
- mem_addr_o  output  MEM_ADDR_WIDTH  SRAM address.
- mem_rdata_i  input  DATA_WIDTH  SRAM read data, valid the cycle after csb low.

Behaviour:
- Reset: one clock, asynchronous active-high reset. On reset:
  - state=IDLE, wait counter=0, address and out-of-range flag registers cleared.
  - slave_data_gnt_o=0, slave_data_rvalid_o=0, slave_data_rdata_o=0.
  - mem_csb_o=1, mem_addr_o=0.
- Reset mid-transaction aborts silently: no gnt and no rvalid are produced for the pending request.
- All outputs are registered or decoded from state only; there are no combinational paths from req or addr to any output.
- States: IDLE, WAIT, ISSUE, RESP.
- IDLE, req=1:
  - Latch addr.
  - Set oor = (addr[SLAVE_ADDR_WIDTH-1:MEM_ADDR_WIDTH] != 0).
  - Load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else ISSUE.
- IDLE, req=0: stay in IDLE.
- WAIT:
  - Decrement the counter each cycle; go to ISSUE when the counter reaches 1 and decrements to 0.
  - req=0 in any WAIT cycle aborts: go to IDLE, no gnt.
- ISSUE:
  - If req=1: gnt=1 for exactly this cycle.
    - If !oor: mem_csb_o=0 and mem_addr_o=latched addr[MEM_ADDR_WIDTH-1:0].
    - Go to RESP.
  - If req=0: abort; csb stays 1, go to IDLE.
- RESP:
  - rvalid=1 for exactly this cycle.
  - rdata register loads mem_rdata_i if !oor, else OOR_DATA.
  - Because rdata is registered, rdata and rvalid appear together at the RESP output edge. Equivalently: rdata_o updates on the ISSUE->RESP+1 edge, and rvalid is registered to align with it. The implementation must present rdata and rvalid in the same cycle.
  - Transitions from RESP behave exactly as from IDLE (back-to-back capture of a new req).
- Latency (WAIT_STATES=N):
  - gnt is asserted N+1 cycles after req first seen high in IDLE.
  - rvalid is asserted 1 cycle after gnt.
  - Back-to-back throughput is one read per N+2 cycles.
- Requester contract: hold req and addr stable until gnt. Address changes before gnt are ignored; the latched address is used.
- slave_data_rdata_o holds its last value outside rvalid cycles.
- Address in range exactly at 2^MEM_ADDR_WIDTH-1 reads the SRAM; 2^MEM_ADDR_WIDTH returns OOR_DATA with normal gnt/rvalid timing and no SRAM access.

Decomposition:
- Shared package (interconnect pkg):
  - State enum type for IDLE/WAIT/ISSUE/RESP.
  - Default OOR_DATA constant.
  - Port width constants shared with the read interconnect (DATA_WIDTH, SLAVE_ADDR_WIDTH).
- No sub-module required. The wait counter is inline.
- The SRAM macro is instantiated outside this block (in the slave wrapper), one responder per interconnect slave port.

Test Plan:
- WAIT_STATES=0; SRAM[5]=32'hCAFE_0005; req=1, addr=5 at cycle 0 -> csb=0 and addr=5 and gnt=1 at cycle 1; rvalid=1 with rdata=32'hCAFE_0005 at cycle 2; rdata held at cycle 3.
- WAIT_STATES=3; req=1, addr=0x20 held -> gnt at cycle 4, rvalid at cycle 5; csb low for exactly one cycle.
- Out of range: addr=10'h100, MEM_ADDR_WIDTH=8 -> gnt and rvalid with normal timing; rdata=OOR_DATA; csb never low. Edge case addr=10'hFF -> SRAM read.
- Abort: WAIT_STATES=2; req=1 at cycle 0, req=0 at cycle 2 -> no gnt, no rvalid, csb stays 1; state returns to IDLE; a fresh req at cycle 4 completes normally.
- Back-to-back: WAIT_STATES=0; req held high with addr 1 then 2 (addr changed after the first gnt) -> gnt at cycles 1 and 3, rvalid at cycles 2 and 4 with SRAM[1] and SRAM[2].
- Reset asserted asynchronously in ISSUE -> gnt, rvalid, and rdata go to 0 and csb goes to 1 immediately (before the next edge); no rvalid after reset release.
